// File: rtl/bsg_dmc_fifo_to_axi_mc.sv
// bsg_dmc_fifo_to_axi_mc: round-robin bridge from per-channel DMC FIFOs to one AXI master port
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   cmd_v_i/cmd_write_i/cmd_addr_i    per-channel burst command in, cmd_ready_o accept
//   wr_v_i/wr_data_i/wr_strb_i        per-channel write beats, wr_ready_o accept
//   rd_v_o/rd_data_o, rd_ready_i      read beats to the granted channel (data shared)
//   err_o                             sticky per-channel response/protocol error
//   axi_aw*/w*/b*/ar*/r*              AXI4 master, one transaction outstanding
module bsg_dmc_fifo_to_axi_mc #(
  parameter int num_ch_p         = 2,
  parameter int axi_id_width_p   = 4,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_burst_len_p  = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic [num_ch_p-1:0]                        cmd_v_i,
  input  logic [num_ch_p-1:0]                        cmd_write_i,
  input  logic [num_ch_p*axi_addr_width_p-1:0]       cmd_addr_i,
  output logic [num_ch_p-1:0]                        cmd_ready_o,
  input  logic [num_ch_p-1:0]                        wr_v_i,
  output logic [num_ch_p-1:0]                        wr_ready_o,
  input  logic [num_ch_p*axi_data_width_p-1:0]       wr_data_i,
  input  logic [num_ch_p*axi_data_width_p/8-1:0]     wr_strb_i,
  output logic [num_ch_p-1:0]                        rd_v_o,
  input  logic [num_ch_p-1:0]                        rd_ready_i,
  output logic [axi_data_width_p-1:0]                rd_data_o,
  output logic [num_ch_p-1:0]                        err_o,
  output logic [axi_id_width_p-1:0]                  axi_awid_o,
  output logic [axi_addr_width_p-1:0]                axi_awaddr_o,
  output logic [7:0]                                 axi_awlen_o,
  output logic                                       axi_awvalid_o,
  input  logic                                       axi_awready_i,
  output logic [axi_data_width_p-1:0]                axi_wdata_o,
  output logic [axi_data_width_p/8-1:0]              axi_wstrb_o,
  output logic                                       axi_wlast_o,
  output logic                                       axi_wvalid_o,
  input  logic                                       axi_wready_i,
  input  logic [axi_id_width_p-1:0]                  axi_bid_i,
  input  logic [1:0]                                 axi_bresp_i,
  input  logic                                       axi_bvalid_i,
  output logic                                       axi_bready_o,
  output logic [axi_id_width_p-1:0]                  axi_arid_o,
  output logic [axi_addr_width_p-1:0]                axi_araddr_o,
  output logic [7:0]                                 axi_arlen_o,
  output logic                                       axi_arvalid_o,
  input  logic                                       axi_arready_i,
  input  logic [axi_id_width_p-1:0]                  axi_rid_i,
  input  logic [axi_data_width_p-1:0]                axi_rdata_i,
  input  logic [1:0]                                 axi_rresp_i,
  input  logic                                       axi_rlast_i,
  input  logic                                       axi_rvalid_i,
  output logic                                       axi_rready_o
);
  localparam int cw = num_ch_p > 1 ? $clog2(num_ch_p) : 1;
  localparam int aw = axi_addr_width_p;
  localparam int dw = axi_data_width_p;
  localparam int sw = axi_data_width_p/8;
  localparam logic [7:0] len_m1 = 8'(axi_burst_len_p-1);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;
  state_e state, state_n;
  logic [cw-1:0] rr_ptr, grant, gnt;
  logic gnt_v, w_hs, r_hs;
  logic [2*num_ch_p-1:0] rot;
  logic [aw-1:0] addr_r;
  logic [7:0] cnt;
  logic [num_ch_p-1:0] err_r, sel;
  logic [axi_id_width_p-1:0] id_g;
  // requests rotated so bit k is channel rr_ptr+k; lowest set bit wins
  always_comb begin
    rot = {cmd_v_i, cmd_v_i} >> rr_ptr;
    gnt_v = 1'b0;
    gnt = '0;
    for (int k = 0; k < num_ch_p; k++)
      if (rot[k] && !gnt_v) begin
        gnt_v = 1'b1;
        gnt = cw'((int'(rr_ptr) + k) % num_ch_p);
      end
  end
  assign sel  = num_ch_p'(1) << grant;
  assign id_g = axi_id_width_p'(grant);
  // gated by reset_n_i so the combinational grant path is also quiet during reset
  assign cmd_ready_o   = (reset_n_i && state == IDLE && gnt_v) ? num_ch_p'(1) << gnt : '0;
  assign axi_awvalid_o = state == AW;
  assign axi_awid_o    = id_g;
  assign axi_awaddr_o  = addr_r;
  assign axi_awlen_o   = len_m1;
  assign axi_arvalid_o = state == AR;
  assign axi_arid_o    = id_g;
  assign axi_araddr_o  = addr_r;
  assign axi_arlen_o   = len_m1;
  assign axi_wvalid_o  = state == W && wr_v_i[grant];
  assign wr_ready_o    = (state == W && axi_wready_i) ? sel : '0;
  assign axi_wdata_o   = wr_data_i[grant*dw +: dw];
  assign axi_wstrb_o   = wr_strb_i[grant*sw +: sw];
  assign axi_wlast_o   = state == W && cnt == len_m1;
  assign axi_bready_o  = state == B;
  assign rd_v_o        = (state == R && axi_rvalid_i) ? sel : '0;
  assign axi_rready_o  = state == R && rd_ready_i[grant];
  assign rd_data_o     = axi_rdata_i;
  assign err_o         = err_r;
  assign w_hs          = axi_wvalid_o && axi_wready_i;
  assign r_hs          = axi_rvalid_i && axi_rready_o;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = gnt_v ? (cmd_write_i[gnt] ? AW : AR) : IDLE;
      AW:      state_n = axi_awready_i ? W : AW;
      W:       state_n = (w_hs && axi_wlast_o) ? B : W;
      B:       state_n = axi_bvalid_i ? IDLE : B;
      AR:      state_n = axi_arready_i ? R : AR;
      R:       state_n = (r_hs && axi_rlast_i) ? IDLE : R;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rr_ptr <= '0;
      grant  <= '0;
      addr_r <= '0;
      cnt    <= '0;
      err_r  <= '0;
    end else begin
      if (state == IDLE && gnt_v) begin
        grant  <= gnt;
        addr_r <= cmd_addr_i[gnt*aw +: aw];
        rr_ptr <= cw'((int'(gnt) + 1) % num_ch_p);
      end
      if (w_hs || r_hs)
        cnt <= ((w_hs && axi_wlast_o) || (r_hs && axi_rlast_i)) ? '0 : cnt + 8'd1;
      if (state == B && axi_bvalid_i && (axi_bresp_i != 2'b00 || axi_bid_i != id_g))
        err_r[grant] <= 1'b1;
      // rlast on the wrong beat is flagged but the burst still ends on rlast
      if (r_hs && (axi_rresp_i != 2'b00 || axi_rid_i != id_g || (axi_rlast_i && cnt != len_m1)))
        err_r[grant] <= 1'b1;
    end
endmodule

// File: doc/bsg_dmc_fifo_to_axi_mc.md
BSG_DMC_FIFO_TO_AXI_MC -- requirements
Module: bsg_dmc_fifo_to_axi_mc

Interface
REQ-001 SHALL have parameter num_ch_p, default 2: number of independent DMC FIFO channels, 1..8.
REQ-002 SHALL have parameter axi_id_width_p, default 4: AXI ID width, >= clog2(num_ch_p).
REQ-003 SHALL have parameter axi_addr_width_p, default 32: AXI and command address width.
REQ-004 SHALL have parameter axi_data_width_p, default 64: AXI and FIFO data width; strobe width axi_data_width_p/8.
REQ-005 SHALL have parameter axi_burst_len_p, default 4: beats per burst, 1..256; awlen/arlen = axi_burst_len_p-1.
REQ-006 SHALL have one clock, clk_i, with asynchronous active-low reset reset_n_i.
REQ-007 clk_i  in  1  sole clock; all state on rising edge.
REQ-008 reset_n_i  in  1  asynchronous, active-low reset.
REQ-009 cmd_v_i / cmd_write_i  in  num_ch_p each  per-channel command valid; 1=write, 0=read.
REQ-010 cmd_addr_i  in  num_ch_p*axi_addr_width_p  per-channel burst start address.
REQ-011 cmd_ready_o  out  num_ch_p  per-channel command accept.
REQ-012 wr_v_i / wr_ready_o  in / out  num_ch_p each  per-channel write-beat handshake.
REQ-013 wr_data_i / wr_strb_i  in  num_ch_p*axi_data_width_p / num_ch_p*axi_data_width_p/8  per-channel write beat.
REQ-014 rd_v_o / rd_ready_i  out / in  num_ch_p each  per-channel read-beat handshake.
REQ-015 rd_data_o  out  axi_data_width_p  read beat, shared by all channels, qualified by rd_v_o.
REQ-016 err_o  out  num_ch_p  sticky per-channel error flag.
REQ-017 AXI AW: axi_awid_o, axi_awaddr_o, axi_awlen_o[7:0], axi_awvalid_o out; axi_awready_i in.
REQ-018 AXI W: axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o out; axi_wready_i in.
REQ-019 AXI B: axi_bid_i, axi_bresp_i[1:0], axi_bvalid_i in; axi_bready_o out.
REQ-020 AXI AR: axi_arid_o, axi_araddr_o, axi_arlen_o[7:0], axi_arvalid_o out; axi_arready_i in.
REQ-021 AXI R: axi_rid_i, axi_rdata_i, axi_rresp_i[1:0], axi_rlast_i, axi_rvalid_i in; axi_rready_o out.

Function
REQ-022 FSM states IDLE, AW, W, B, AR, R; exactly one outstanding AXI transaction at any time.
REQ-023 IDLE: grant = first channel with cmd_v_i set, searching from rr_ptr upward with wrap; cmd_ready_o[grant]=1 combinationally in the same cycle; all other cmd_ready_o = 0.
REQ-024 On grant: latch channel, address and write flag; rr_ptr <= (grant+1) mod num_ch_p; next state AW if write, else AR; no command accepted outside IDLE.
REQ-025 AW/AR: valid asserted the cycle after acceptance, held with stable id = zero-extended grant, address and len until ready; AW -> W, AR -> R on handshake.
REQ-026 W: axi_wvalid_o = wr_v_i[grant]; wr_ready_o[grant] = axi_wready_i; data/strb muxed from grant; beat counter increments per handshake; axi_wlast_o = (counter == axi_burst_len_p-1); after last handshake counter clears, go to B.
REQ-027 B: axi_bready_o=1; on axi_bvalid_i go to IDLE; set err_o[grant] if bresp != 0 or bid != grant.
REQ-028 R: rd_v_o[grant] = axi_rvalid_i; axi_rready_o = rd_ready_i[grant]; rd_data_o = axi_rdata_i; on rvalid & rready & rlast go to IDLE.
REQ-029 R errors: set err_o[grant] if any beat has rresp != 0 or rid != grant, or rlast arrives on a beat other than axi_burst_len_p-1; state still exits only on rlast.
REQ-030 Non-granted channels see ready/valid outputs 0; a channel's cmd_v_i held while another is served is granted no later than num_ch_p-1 transactions later.
REQ-031 Back-to-back: earliest next grant is the cycle after B or last R handshake (IDLE dwell of 1 cycle).
REQ-032 err_o bits are sticky; cleared only by reset.

Reset
REQ-033 While reset_n_i=0: state IDLE, rr_ptr 0, beat counter 0, err_o 0, and every valid/ready output (cmd_ready_o, wr_ready_o, rd_v_o, axi_*valid_o, axi_bready_o, axi_rready_o) 0, asynchronously.
REQ-034 Reset asserted mid-burst SHALL abandon the transaction; after release the block starts in IDLE with no replay.

Verification
REQ-035 num_ch_p=2, len 4: ch0 write to 0x1000, awready and wready always 1 -> awvalid cycle after accept, 4 W beats, wlast on beat 4, bready, back to IDLE; err_o=0.
REQ-036 ch0 and ch1 cmd_v_i held continuously -> grants alternate 0,1,0,1; awid/arid match the granted channel.
REQ-037 ch1 read, rready throttled by rd_ready_i[1] toggling -> all 4 beats delivered in order to rd_v_o[1] only; rd_v_o[0] stays 0.
REQ-038 bresp=2'b10 on ch0 write -> err_o=2'b01 and stays set through later clean transactions.
REQ-039 rlast on beat 2 of 4, or rid mismatch -> err_o[grant]=1, FSM returns to IDLE on rlast.
REQ-040 reset_n_i pulsed low during W beat 2 -> all outputs 0 immediately; after release a new command is granted from ch0.
